// File: rtl/multi_timer.sv
// rtl/multi_timer.sv - N_CH independent down-counting interval timers with tick pulses and sticky irqs
module multi_timer #(
    parameter int N_CH           = 4,
    parameter int WIDTH          = 32,
    parameter int DEFAULT_PERIOD = 50000000,
    localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [WIDTH-1:0]  cfg_period,
    input  logic              cfg_oneshot,
    input  logic [N_CH-1:0]   start,
    input  logic [N_CH-1:0]   stop,
    input  logic [N_CH-1:0]   irq_ack,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   irq,
    output logic              irq_any,
    output logic [N_CH-1:0]   running
);

    logic [WIDTH-1:0] cnt_q    [N_CH];
    logic [WIDTH-1:0] cnt_d    [N_CH];
    logic [WIDTH-1:0] period_q [N_CH];
    logic [WIDTH-1:0] period_d [N_CH];
    logic [N_CH-1:0]  oneshot_q, oneshot_d;
    logic [N_CH-1:0]  running_q, running_d;
    logic [N_CH-1:0]  tick_q, tick_d;
    logic [N_CH-1:0]  irq_q, irq_d;
    logic [WIDTH-1:0] eff;
    logic             expire;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                cnt_q[c]    <= '0;
                period_q[c] <= WIDTH'(DEFAULT_PERIOD);
            end
            oneshot_q <= '0;
            running_q <= '0;
            tick_q    <= '0;
            irq_q     <= '0;
        end else begin
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            running_q <= running_d;
            tick_q    <= tick_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        running_d = running_q;
        tick_d    = '0;
        irq_d     = irq_q;
        eff       = '0;
        expire    = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            // A write landing on this edge is already visible to start/reload; out-of-range cfg_ch never matches.
            if (cfg_we && (int'(cfg_ch) == c)) begin
                eff          = cfg_period;
                period_d[c]  = cfg_period;
                oneshot_d[c] = cfg_oneshot;
            end else begin
                eff = period_q[c];
            end
            expire = 1'b0;
            if (stop[c]) begin
                running_d[c] = 1'b0;
            end else if (start[c]) begin
                if (eff != '0) begin
                    cnt_d[c]     = eff - WIDTH'(1);
                    running_d[c] = 1'b1;
                end
            end else if (running_q[c] && (cnt_q[c] == '0)) begin
                expire    = 1'b1;
                tick_d[c] = 1'b1;
                // A period of zero cannot be reloaded without wrapping, so the channel halts instead.
                if (oneshot_q[c] || (eff == '0)) begin
                    running_d[c] = 1'b0;
                end else begin
                    cnt_d[c] = eff - WIDTH'(1);
                end
            end else if (running_q[c]) begin
                cnt_d[c] = cnt_q[c] - WIDTH'(1);
            end
            irq_d[c] = (irq_q[c] & ~irq_ack[c]) | expire;
        end
    end

    assign tick    = tick_q;
    assign irq     = irq_q;
    assign running = running_q;
    assign irq_any = |irq_q;

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Parametrised, multi-channel successor to the single free-running interval timer. It provides N_CH independent down-counting timers, each with its own programmable period and a one-shot or periodic mode. Each channel produces a single-cycle tick pulse and a sticky, acknowledgeable interrupt flag. It sits between the 50 MHz system clock domain and the CPU/game-logic interrupt inputs, and replaces the combinational modulo compare.

Parameters:
N_CH, 4, number of independent timer channels (1..16)
WIDTH, 32, period/counter width in bits
DEFAULT_PERIOD, 50000000, period loaded into every channel on reset (1 s at 50 MHz); must be < 2**WIDTH
CH_W, (N_CH>1 ? $clog2(N_CH) : 1), channel-select width (derived, do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
cfg_we  in  1  write cfg_period/cfg_oneshot into channel cfg_ch
cfg_ch  in  CH_W  channel select for configuration write
cfg_period  in  WIDTH  period in clock cycles
cfg_oneshot  in  1  1 = one-shot, 0 = periodic
start  in  N_CH  per-channel start/restart request, level sampled each edge
stop  in  N_CH  per-channel stop request
irq_ack  in  N_CH  per-channel interrupt clear
tick  out  N_CH  one-cycle pulse on each channel expiry
irq  out  N_CH  sticky per-channel interrupt flag
irq_any  out  1  OR-reduction of irq
running  out  N_CH  channel is counting

Behaviour:
- Reset (async, active-high): cnt=0, running=0, tick=0, irq=0, period=DEFAULT_PERIOD, oneshot=0 for all channels. irq_any=0.
- Config write on an edge with cfg_we=1 and cfg_ch<N_CH: sets period[cfg_ch]/oneshot[cfg_ch]. cfg_ch>=N_CH: write ignored.
- Writes to a running channel do not disturb cnt. The new period applies at the next reload or start.
- Effective period: E = cfg_period if a same-cycle write targets that channel, else the stored period.
- Per-channel priority, evaluated each edge, highest first:
  1. stop=1: running<=0, tick<=0, cnt holds. Stop beats start.
  2. start=1: if E==0, start is ignored and running is unchanged. Otherwise cnt<=E-1, running<=1, tick<=0. This restarts a channel that is already running.
  3. running=1 and cnt==0 (expiry): tick<=1, irq<=1. Periodic: cnt<=period-1, stays running. One-shot: running<=0, cnt stays 0.
  4. running=1 and cnt!=0: cnt<=cnt-1, tick<=0.
  5. Otherwise tick<=0.
- Timing: start sampled at edge t0 gives tick high for exactly one cycle after edge t0+P. Periodic mode repeats at t0+2P, t0+3P, and so on. P=1 gives tick high every cycle.
- irq: set on expiry, cleared by irq_ack on an edge. Expiry and ack on the same edge: irq stays 1, so set wins. Ack with no pending irq has no effect.
- irq_any is combinational OR of the irq registers. All other outputs are registered.
- Arithmetic: counters are unsigned WIDTH-bit and never underflow, because reload occurs at 0. No modulo or divide hardware is permitted.
- Channels are fully independent. Simultaneous expiries on several channels each set their own irq and tick in the same cycle.
- Reset asserted mid-count aborts all channels immediately. After release, channels remain idle until start.

Test Plan:
1. Reset, write ch0 period=5 periodic, pulse start[0] at edge t0 -> tick[0] high in the cycles after t0+5, t0+10, t0+15, each for one cycle; irq[0]=1 from t0+5; irq_any=1.
2. Ch1 one-shot period=3, start -> single tick after t0+3; running[1] falls at the same edge; no further ticks over 20 cycles; irq_ack[1] clears irq[1] at the next edge.
3. Ch2 running with period=4; assert irq_ack[2] on the expiry edge -> irq[2] remains 1. Assert start[2] and stop[2] together -> running[2]=0 and no tick.
4. Period=0 start on ch3 -> running[3] stays 0. Period=1 periodic -> tick[3] high continuously after the start edge.
5. Ch0 running period=10; at cnt=6 write period=2 -> current interval still completes at 10 cycles, later intervals are 2 cycles. Write with cfg_ch=N_CH (N_CH non-power-of-two build, e.g. 3) -> no channel changes.
6. Assert reset mid-count on all channels -> all outputs 0 asynchronously (before the next edge); periods return to DEFAULT_PERIOD; no tick after release without start.
